// File: rtl/button_debouncer.sv
// Push-button debouncer sampled on rising edges of div_clk; emits level, press/release pulses.
// Optional long-press pulse enabled by defining BUTTON_DEBOUNCER_LONG_PRESS_EN.
module button_debouncer #(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 64
) (
    input  logic org_clk,
    input  logic sys_rst,
    input  logic div_clk,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_long
);
    localparam int CW = $clog2(STABLE_TICKS + 1);

    if (STABLE_TICKS < 2 || STABLE_TICKS > 255) begin : g_bad_stable
        $error("STABLE_TICKS out of range 2..255");
    end
    if (LONG_TICKS < 1 || LONG_TICKS > 65535) begin : g_bad_long
        $error("LONG_TICKS out of range 1..65535");
    end

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_inc;
    logic            cnt_done;
    logic            div_clk_q;
    logic            sync1_q;
    logic            sync2_q;
    logic            tick;
    logic            level_q;
    logic            press_q;
    logic            release_q;

    assign tick     = div_clk & ~div_clk_q;
    assign cnt_inc  = cnt_q + CW'(1);
    assign cnt_done = (cnt_inc == CW'(STABLE_TICKS));

    always_ff @(posedge org_clk) begin
        if (sys_rst) begin
            div_clk_q <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
        end else begin
            div_clk_q <= div_clk;
            sync1_q   <= btn_raw;
            sync2_q   <= sync1_q;
        end
    end

    always_ff @(posedge org_clk) begin
        if (sys_rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            if (tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (sync2_q) begin
                            state_q <= PRESS_WAIT;
                            cnt_q   <= CW'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_q) begin
                            state_q <= IDLE;
                            cnt_q   <= '0;
                        end else if (cnt_done) begin
                            state_q <= PRESSED;
                            cnt_q   <= '0;
                            level_q <= 1'b1;
                            press_q <= 1'b1;
                        end else begin
                            cnt_q   <= cnt_inc;
                        end
                    end
                    PRESSED: begin
                        if (!sync2_q) begin
                            state_q <= RELEASE_WAIT;
                            cnt_q   <= CW'(1);
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2_q) begin
                            state_q   <= PRESSED;
                            cnt_q     <= '0;
                        end else if (cnt_done) begin
                            state_q   <= IDLE;
                            cnt_q     <= '0;
                            level_q   <= 1'b0;
                            release_q <= 1'b1;
                        end else begin
                            cnt_q     <= cnt_inc;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;

`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    logic [15:0] hold_q;
    logic [15:0] hold_inc;
    logic        long_q;

    assign hold_inc = hold_q + 16'd1;

    // Count survives RELEASE_WAIT so a release bounce does not re-arm the long pulse.
    always_ff @(posedge org_clk) begin
        if (sys_rst) begin
            hold_q <= '0;
            long_q <= 1'b0;
        end else begin
            long_q <= 1'b0;
            if (tick) begin
                if (state_q == PRESSED && hold_q != 16'(LONG_TICKS)) begin
                    hold_q <= hold_inc;
                    if (hold_inc == 16'(LONG_TICKS)) begin
                        long_q <= 1'b1;
                    end
                end else if (state_q == RELEASE_WAIT && !sync2_q && cnt_done) begin
                    hold_q <= '0;
                end
            end
        end
    end

    assign btn_long = long_q;
`else
    assign btn_long = 1'b0;
`endif

endmodule

// File: tb/tb_button_debouncer.sv
// Randomized bench for button_debouncer against a run-length reference model.
module tb_button_debouncer;
    localparam int ST = 4;
    localparam int LT = 5;
`ifdef BUTTON_DEBOUNCER_LONG_PRESS_EN
    localparam bit LONG_EN = 1'b1;
`else
    localparam bit LONG_EN = 1'b0;
`endif

    logic org_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic div_clk = 1'b0;
    logic btn_raw = 1'b0;
    logic btn_level, btn_press, btn_release, btn_long;

    button_debouncer #(.STABLE_TICKS(ST), .LONG_TICKS(LT)) dut (
        .org_clk     (org_clk),
        .sys_rst     (sys_rst),
        .div_clk     (div_clk),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .btn_long    (btn_long)
    );

    always #5 org_clk = ~org_clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: accepted level plus length of the current run of disagreeing samples.
    logic m_s1 = 0, m_s2 = 0, m_dv = 0;
    logic m_level = 0, m_press = 0, m_rel = 0, m_long = 0;
    int   m_run = 0, m_hold = 0;

    int   dcnt = 0;
    bit   stall = 0;
    int   n_press = 0, n_rel = 0, n_long = 0;

    task automatic model_edge(input logic raw, input logic dv, input logic rst);
        logic tk;
        if (rst) begin
            m_s1 = 0; m_s2 = 0; m_dv = 0;
            m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
            m_run = 0; m_hold = 0;
        end else begin
            tk = dv && !m_dv;
            m_press = 0; m_rel = 0; m_long = 0;
            if (tk) begin
                if (LONG_EN && m_level && m_run == 0 && m_hold < LT) begin
                    m_hold++;
                    if (m_hold == LT) m_long = 1;
                end
                if (m_s2 != m_level) begin
                    m_run++;
                    if (m_run == ST) begin
                        m_level = !m_level;
                        m_run   = 0;
                        if (m_level) m_press = 1;
                        else begin
                            m_rel  = 1;
                            m_hold = 0;
                        end
                    end
                end else begin
                    m_run = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = raw;
            m_dv = dv;
        end
    endtask

    task automatic step(input logic raw, input logic rst);
        logic dv;
        dv = stall ? 1'b1 : ((dcnt % 8) >= 4);
        btn_raw = raw;
        sys_rst = rst;
        div_clk = dv;
        @(posedge org_clk);
        model_edge(raw, dv, rst);
        dcnt++;
        @(negedge org_clk);
        chk("level",   btn_level,   m_level);
        chk("press",   btn_press,   m_press);
        chk("release", btn_release, m_rel);
        chk("long",    btn_long,    m_long);
        chk("press_release_excl", btn_press & btn_release, 0);
        if (btn_press === 1'b1)   n_press++;
        if (btn_release === 1'b1) n_rel++;
        if (btn_long === 1'b1)    n_long++;
    endtask

    task automatic run_ticks(input logic raw, input int n);
        for (int k = 0; k < n * 8; k++) step(raw, 1'b0);
    endtask

    int p0, r0, l0;
    logic lvl, r;
    int len;

    initial begin
        for (int k = 0; k < 3; k++) step(1'b0, 1'b1);
        run_ticks(1'b0, 3);

        // clean press
        p0 = n_press; r0 = n_rel;
        run_ticks(1'b1, 8);
        chk("clean_press_count", n_press - p0, 1);
        chk("clean_press_no_rel", n_rel - r0, 0);
        chk("clean_press_level", btn_level, 1);

        // release with one-tick glitch
        p0 = n_press; r0 = n_rel;
        run_ticks(1'b0, 2);
        run_ticks(1'b1, 1);
        chk("glitch_level_held", btn_level, 1);
        run_ticks(1'b0, 8);
        chk("glitch_rel_count", n_rel - r0, 1);
        chk("glitch_no_press", n_press - p0, 0);

        // bouncy press
        p0 = n_press;
        run_ticks(1'b1, 1);
        run_ticks(1'b0, 1);
        run_ticks(1'b1, 7);
        chk("bouncy_press_count", n_press - p0, 1);
        run_ticks(1'b0, 6);
        chk("bouncy_released", btn_level, 0);

        // reset mid-wait
        for (int k = 0; k < 100 && !(m_run == 2 && !m_level); k++) step(1'b1, 1'b0);
        r0 = n_rel; p0 = n_press;
        step(1'b1, 1'b1);
        chk("rst_level", btn_level, 0);
        run_ticks(1'b1, 2);
        chk("rst_no_early_press", n_press - p0, 0);
        run_ticks(1'b1, 4);
        chk("rst_fresh_press", n_press - p0, 1);
        chk("rst_no_release", n_rel - r0, 0);
        run_ticks(1'b0, 6);

        // stalled divider
        p0 = n_press;
        stall = 1;
        for (int k = 0; k < 100; k++) step(1'b1, 1'b0);
        chk("stall_no_press", n_press - p0, 0);
        chk("stall_level", btn_level, 0);
        stall = 0;
        run_ticks(1'b1, 6);
        chk("stall_resume_press", n_press - p0, 1);

        // long hold: one long pulse at most
        l0 = n_long;
        run_ticks(1'b1, 20);
        chk("long_count", n_long - l0, LONG_EN ? 1 : 0);
        run_ticks(1'b0, 6);

        // randomized bouncing with occasional resets and stalls
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 29) == 0) stall = !stall;
            lvl = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 40);
            for (int j = 0; j < len; j++) begin
                r = ($urandom_range(0, 9) == 0) ? !lvl : lvl;
                step(r, ($urandom_range(0, 199) == 0));
            end
        end
        stall = 0;
        run_ticks(1'b0, 6);
        chk("final_level", btn_level, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/button_debouncer.md
# button_debouncer

Debounces one raw push-button input. It uses the divided clock from the frequency divider as its sample strobe, and everything runs on the single system clock. It emits a clean level, one-cycle press and release pulses, and optionally a long-press pulse to the game-control logic downstream. It sits directly after the frequency divider: its `div_clk` output is this block's sampling time base.

## Interface

Parameters:

- `STABLE_TICKS`, default 4: consecutive equal samples required to accept a new level. Legal range 2..255.
- `LONG_TICKS`, default 64: samples the button must stay accepted-high before `btn_long` fires. Legal range 1..65535. Used only with the macro defined.

Ports:

- `org_clk` input, 1 bit: system clock. Every register in the block is clocked on its rising edge.
- `sys_rst` input, 1 bit: synchronous, active-high reset.
- `div_clk` input, 1 bit: divided clock from the frequency divider, registered in the `org_clk` domain. Used only as data, never as a clock.
- `btn_raw` input, 1 bit: asynchronous, bouncing button; 1 means pressed.
- `btn_level` output, 1 bit: debounced level.
- `btn_press` output, 1 bit: one-cycle pulse when the level rises.
- `btn_release` output, 1 bit: one-cycle pulse when the level falls.
- `btn_long` output, 1 bit: one-cycle long-press pulse. Constant 0 without the macro.

## Operation

- Tick generation:
  - Register `div_clk_d` (reset 0).
  - `tick = div_clk & ~div_clk_d`: one `org_clk` cycle per rising edge of `div_clk`.
  - No other logic may advance on non-tick cycles.
- Input synchronizer:
  - `btn_raw` passes through a 2-flop synchronizer (both flops reset 0) to give `btn_sync`.
  - `btn_sync` is the only version of the button the FSM reads.
- Stability counter: `cnt`, width `$clog2(STABLE_TICKS+1)`, reset 0.
- FSM states: IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE. All transitions below happen only on tick cycles.
  - IDLE:
    - `btn_sync`=1 -> PRESS_WAIT, `cnt`=1.
    - Otherwise stay, `cnt`=0.
  - PRESS_WAIT:
    - `btn_sync`=0 -> IDLE, `cnt`=0.
    - Else if `cnt`+1 == `STABLE_TICKS` -> PRESSED, `cnt`=0, `btn_level`<=1, `btn_press`<=1.
    - Else `cnt`++.
  - PRESSED:
    - `btn_sync`=0 -> RELEASE_WAIT, `cnt`=1.
    - Otherwise stay.
  - RELEASE_WAIT:
    - `btn_sync`=1 -> PRESSED, `cnt`=0, no pulse.
    - Else if `cnt`+1 == `STABLE_TICKS` -> IDLE, `cnt`=0, `btn_level`<=0, `btn_release`<=1.
    - Else `cnt`++.
- Output pulses:
  - `btn_press`, `btn_release` and `btn_long` are registered and cleared on every cycle they are not being set. Each is therefore exactly 1 `org_clk` cycle wide.
  - `btn_press` and `btn_release` are never high in the same cycle.
- Bounce: any sample that disagrees during a WAIT state aborts back to the prior stable state, with no output change and no pulse.
- `div_clk` stuck at either level: no ticks, so the FSM and counters freeze and all pulses stay 0.

## Timing

- Reset values: `btn_level`, `btn_press`, `btn_release` and `btn_long` are all 0. State is IDLE; `cnt`, the hold counter, the synchronizer flops and `div_clk_d` are all 0.
- Reset mid-operation:
  - Any in-progress wait is abandoned.
  - `btn_level` returns to 0 with no `btn_release` pulse.
  - No pulse occurs in the cycle after reset deasserts.
- Synchronizer latency: 2 cycles from `btn_raw` to `btn_sync`.
- Press latency:
  - `btn_level` rises on the `org_clk` edge of the STABLE_TICKS-th consecutive tick that samples `btn_sync`=1.
  - `btn_press` is high during the cycle after that edge.
  - With a divide ratio of N, worst case is 2 + `STABLE_TICKS`·N cycles after a clean edge.
- Release latency: symmetric with press latency.

## Configuration

- `BUTTON_DEBOUNCER_LONG_PRESS_EN` defined:
  - Adds a 16-bit hold counter, reset 0.
  - It increments on each tick spent in PRESSED and saturates at `LONG_TICKS`.
  - On the tick where it reaches `LONG_TICKS`, `btn_long` pulses once per press.
  - The counter is held in RELEASE_WAIT, so a bounce back to PRESSED keeps the count.
  - It clears on entry to IDLE.
- Macro undefined: no hold counter is built and `btn_long` is tied to 0.

## Test plan

All tests use `div_clk` = divider with N=8 (a tick every 8 `org_clk` cycles) and `STABLE_TICKS`=4.

- Clean press:
  - Stimulus: `btn_raw` 0->1 and held.
  - Response: `btn_level`=1 after the 4th high tick, `btn_press` high for exactly 1 cycle, `btn_release`=0 throughout.
- Bouncy press:
  - Stimulus: `btn_raw` toggles 1,0,1 across the first 3 ticks, then stays high.
  - Response: no output change until 4 consecutive high ticks, then a single `btn_press`.
- Release with glitch:
  - Stimulus: from PRESSED, 0 for 2 ticks, 1 for 1 tick, then 0 steadily.
  - Response: `btn_level` stays 1 through the glitch, then falls after 4 consecutive low ticks with one `btn_release`.
- Reset mid-wait:
  - Stimulus: assert `sys_rst` 1 cycle while in PRESS_WAIT (`cnt`=2), with `btn_raw` still high.
  - Response: all outputs 0, and a fresh 4-tick wait is required before `btn_press`.
- Stalled divider:
  - Stimulus: hold `div_clk`=1 for 100 cycles while `btn_raw`=1.
  - Response: no output change; normal behaviour resumes once ticks restart.
- Long press (macro defined, `LONG_TICKS`=5):
  - Stimulus: hold the button.
  - Response: `btn_long` pulses exactly once, on the 5th tick after `btn_press`; a 20-tick hold still gives only one pulse.
